// File: rtl/soc_pkg.sv
// Shared definitions for the tinyriscv SoC slice: bus width, memory map,
// default memory depths, the RV32I major opcodes and the address decoder.
package soc_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  // Region select lives in the top nibble of the byte address.
  localparam int unsigned SEL_MSB = 31;
  localparam int unsigned SEL_LSB = 28;

  localparam logic [XLEN-1:0] ROM_BASE = 32'h0000_0000;
  localparam logic [XLEN-1:0] RAM_BASE = 32'h1000_0000;

  localparam int unsigned ROM_DEPTH_DEF = 4096;
  localparam int unsigned RAM_DEPTH_DEF = 4096;

  typedef enum logic [1:0] {
    SLV_ROM,
    SLV_RAM,
    SLV_NONE
  } slave_e;

  typedef enum logic [6:0] {
    OP_LUI    = 7'h37,
    OP_AUIPC  = 7'h17,
    OP_JAL    = 7'h6F,
    OP_JALR   = 7'h67,
    OP_BRANCH = 7'h63,
    OP_LOAD   = 7'h03,
    OP_STORE  = 7'h23,
    OP_IMM    = 7'h13,
    OP_REG    = 7'h33
  } opcode_e;

  function automatic slave_e decode_slave(input logic [XLEN-1:0] addr);
    if (addr[SEL_MSB:SEL_LSB] == ROM_BASE[SEL_MSB:SEL_LSB]) return SLV_ROM;
    if (addr[SEL_MSB:SEL_LSB] == RAM_BASE[SEL_MSB:SEL_LSB]) return SLV_RAM;
    return SLV_NONE;
  endfunction

endpackage

// File: rtl/soc_bus_if.sv
// Data-bus bundle between the core and the memory slaves.
//   addr  : byte address        we    : write strobe
//   be    : byte enables        wdata : write data (byte i in lane i)
//   rdata : combinational read data returned by the slave
interface soc_bus_if;
  import soc_pkg::*;

  logic [XLEN-1:0] addr;
  logic            we;
  logic [BE_W-1:0] be;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;

  modport master (output addr, we, be, wdata, input rdata);
  modport slave  (input addr, we, be, wdata, output rdata);
endinterface

// File: rtl/gen_ram.sv
// Generic dual-port memory, byte-enable synchronous writes, combinational
// reads. Reads see the array before the edge, so a same-cycle write to the
// read address becomes visible the following cycle. No reset on contents.
//   clk                 : write clock
//   a_*/b_*             : word index, write strobe, byte enables,
//                         write data, read data for each port
module gen_ram
  import soc_pkg::*;
#(
  parameter int unsigned DEPTH = 4096
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] a_idx,
  input  logic                     a_we,
  input  logic [BE_W-1:0]          a_be,
  input  logic [XLEN-1:0]          a_wdata,
  output logic [XLEN-1:0]          a_rdata,
  input  logic [$clog2(DEPTH)-1:0] b_idx,
  input  logic                     b_we,
  input  logic [BE_W-1:0]          b_be,
  input  logic [XLEN-1:0]          b_wdata,
  output logic [XLEN-1:0]          b_rdata
);

  logic [XLEN-1:0] ram [0:DEPTH-1];

  // Port B is applied last, so it wins a same-byte collision.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (a_we && a_be[i]) ram[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
      if (b_we && b_be[i]) ram[b_idx][8*i +: 8] <= b_wdata[8*i +: 8];
    end
  end

  assign a_rdata = ram[a_idx];
  assign b_rdata = ram[b_idx];

endmodule

// File: rtl/tinyriscv_core.sv
// Single-cycle RV32I core: one instruction fetched, executed and retired per
// clock. FENCE/SYSTEM and unknown opcodes execute as no-ops.
//   clk, rst_n              : clock, async active-low reset (PC, GPRs)
//   ibus_addr / ibus_rdata  : instruction fetch address / word
//   dbus_*                  : data bus (combinational read, write on edge)
module tinyriscv_gpr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs [0:31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

module tinyriscv_core
  import soc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] ibus_addr,
  input  logic [XLEN-1:0] ibus_rdata,
  output logic [XLEN-1:0] dbus_addr,
  output logic            dbus_we,
  output logic [BE_W-1:0] dbus_be,
  output logic [XLEN-1:0] dbus_wdata,
  input  logic [XLEN-1:0] dbus_rdata
);

  logic [31:0] pc, pc_next, inst;
  logic [31:0] rs1_val, rs2_val, rd_val, ld_shift, ld_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        rd_we, br_taken;
  opcode_e     opcode;

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] y;
    case (f3)
      3'b000:  y = alt ? a - b : a + b;
      3'b001:  y = a << b[4:0];
      3'b010:  y = {31'b0, $signed(a) < $signed(b)};
      3'b011:  y = {31'b0, a < b};
      3'b100:  y = a ^ b;
      3'b101: begin
        if (alt) y = $signed(a) >>> b[4:0];
        else     y = a >> b[4:0];
      end
      3'b110:  y = a | b;
      default: y = a & b;
    endcase
    return y;
  endfunction

  assign ibus_addr = pc;
  assign inst      = ibus_rdata;
  assign opcode    = opcode_e'(inst[6:0]);

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  tinyriscv_gpr u_gpr_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (rd_we),
    .waddr  (inst[11:7]),
    .wdata  (rd_val),
    .raddr1 (inst[19:15]),
    .raddr2 (inst[24:20]),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  always_comb begin
    case (inst[14:12])
      3'b000:  br_taken = rs1_val == rs2_val;
      3'b001:  br_taken = rs1_val != rs2_val;
      3'b100:  br_taken = $signed(rs1_val) <  $signed(rs2_val);
      3'b101:  br_taken = $signed(rs1_val) >= $signed(rs2_val);
      3'b110:  br_taken = rs1_val <  rs2_val;
      3'b111:  br_taken = rs1_val >= rs2_val;
      default: br_taken = 1'b0;
    endcase
  end

  // Load data arrives as a full word; shift the addressed lane down first.
  always_comb begin
    ld_shift = dbus_rdata >> {dbus_addr[1:0], 3'b000};
    case (inst[14:12])
      3'b000:  ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_val = {24'b0, ld_shift[7:0]};
      3'b101:  ld_val = {16'b0, ld_shift[15:0]};
      default: ld_val = dbus_rdata;
    endcase
  end

  always_comb begin
    pc_next    = pc + 32'd4;
    rd_we      = 1'b0;
    rd_val     = '0;
    dbus_addr  = rs1_val + imm_i;
    dbus_we    = 1'b0;
    dbus_be    = '0;
    dbus_wdata = '0;
    case (opcode)
      OP_LUI:   begin rd_we = 1'b1; rd_val = imm_u; end
      OP_AUIPC: begin rd_we = 1'b1; rd_val = pc + imm_u; end
      OP_JAL: begin
        rd_we = 1'b1; rd_val = pc + 32'd4; pc_next = pc + imm_j;
      end
      OP_JALR: begin
        rd_we = 1'b1; rd_val = pc + 32'd4; pc_next = (rs1_val + imm_i) & ~32'h1;
      end
      OP_BRANCH: if (br_taken) pc_next = pc + imm_b;
      OP_LOAD:  begin rd_we = 1'b1; rd_val = ld_val; end
      OP_STORE: begin
        dbus_addr = rs1_val + imm_s;
        // Held off while in reset so a store at PC 0 cannot corrupt memory.
        dbus_we   = rst_n;
        case (inst[13:12])
          2'b00: begin
            dbus_be    = 4'b0001 << dbus_addr[1:0];
            dbus_wdata = {4{rs2_val[7:0]}};
          end
          2'b01: begin
            dbus_be    = 4'b0011 << {dbus_addr[1], 1'b0};
            dbus_wdata = {2{rs2_val[15:0]}};
          end
          default: begin
            dbus_be    = '1;
            dbus_wdata = rs2_val;
          end
        endcase
      end
      OP_IMM: begin
        rd_we  = 1'b1;
        rd_val = alu(inst[14:12], (inst[14:12] == 3'b101) && inst[30], rs1_val, imm_i);
      end
      OP_REG: begin
        rd_we  = 1'b1;
        rd_val = alu(inst[14:12], inst[30], rs1_val, rs2_val);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= ROM_BASE;
    else        pc <= pc_next;
  end

endmodule

// File: rtl/tiny_riscv_soc_top.sv
// Simulation/compliance SoC top: reset synchronizer, tinyriscv core, ROM
// (instruction port + data port) and RAM, with the data bus decoded on
// addr[31:28]: 0x0 ROM, 0x1 RAM, anything else reads 0 and drops writes.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
module soc_rom
  import soc_pkg::*;
#(
  parameter int unsigned DEPTH = ROM_DEPTH_DEF
) (
  input  logic            clk,
  input  logic [XLEN-1:0] ibus_addr,
  output logic [XLEN-1:0] ibus_rdata,
  soc_bus_if.slave        bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{ibus_addr[XLEN-1:AW+2], ibus_addr[1:0],
                              bus.addr[XLEN-1:AW+2], bus.addr[1:0]};

  gen_ram #(.DEPTH(DEPTH)) u_gen_ram (
    .clk     (clk),
    .a_idx   (ibus_addr[AW+1:2]),
    .a_we    (1'b0),
    .a_be    ('0),
    .a_wdata ('0),
    .a_rdata (ibus_rdata),
    .b_idx   (bus.addr[AW+1:2]),
    .b_we    (bus.we),
    .b_be    (bus.be),
    .b_wdata (bus.wdata),
    .b_rdata (bus.rdata)
  );

endmodule

module soc_ram
  import soc_pkg::*;
#(
  parameter int unsigned DEPTH = RAM_DEPTH_DEF
) (
  input  logic     clk,
  soc_bus_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic            unused_addr_bits;
  logic [XLEN-1:0] unused_a_rdata;
  assign unused_addr_bits = ^{bus.addr[XLEN-1:AW+2], bus.addr[1:0]};

  gen_ram #(.DEPTH(DEPTH)) u_gen_ram (
    .clk     (clk),
    .a_idx   ('0),
    .a_we    (1'b0),
    .a_be    ('0),
    .a_wdata ('0),
    .a_rdata (unused_a_rdata),
    .b_idx   (bus.addr[AW+1:2]),
    .b_we    (bus.we),
    .b_be    (bus.be),
    .b_wdata (bus.wdata),
    .b_rdata (bus.rdata)
  );

endmodule

module tiny_riscv_soc_top
  import soc_pkg::*;
#(
  parameter int unsigned ROM_DEPTH = ROM_DEPTH_DEF,
  parameter int unsigned RAM_DEPTH = RAM_DEPTH_DEF
) (
  input logic clk,
  input logic rst_n
);

  logic [1:0]      rst_sync;
  logic            core_rst_n;
  logic [XLEN-1:0] ibus_addr, ibus_rdata;
  slave_e          dsel;

  soc_bus_if dbus ();
  soc_bus_if rom_bus ();
  soc_bus_if ram_bus ();

  // Asserts asynchronously, releases two rising edges after rst_n goes high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign core_rst_n = rst_sync[1];

  tinyriscv_core u_tinyriscv_core (
    .clk        (clk),
    .rst_n      (core_rst_n),
    .ibus_addr  (ibus_addr),
    .ibus_rdata (ibus_rdata),
    .dbus_addr  (dbus.addr),
    .dbus_we    (dbus.we),
    .dbus_be    (dbus.be),
    .dbus_wdata (dbus.wdata),
    .dbus_rdata (dbus.rdata)
  );

  assign dsel = decode_slave(dbus.addr);

  assign rom_bus.addr  = dbus.addr;
  assign rom_bus.we    = dbus.we && (dsel == SLV_ROM);
  assign rom_bus.be    = dbus.be;
  assign rom_bus.wdata = dbus.wdata;

  assign ram_bus.addr  = dbus.addr;
  assign ram_bus.we    = dbus.we && (dsel == SLV_RAM);
  assign ram_bus.be    = dbus.be;
  assign ram_bus.wdata = dbus.wdata;

  always_comb begin
    dbus.rdata = '0;
    case (dsel)
      SLV_ROM: dbus.rdata = rom_bus.rdata;
      SLV_RAM: dbus.rdata = ram_bus.rdata;
      default: dbus.rdata = '0;
    endcase
  end

  soc_rom #(.DEPTH(ROM_DEPTH)) u_rom (
    .clk        (clk),
    .ibus_addr  (ibus_addr),
    .ibus_rdata (ibus_rdata),
    .bus        (rom_bus)
  );

  soc_ram #(.DEPTH(RAM_DEPTH)) u_ram (
    .clk (clk),
    .bus (ram_bus)
  );

endmodule

// File: tb/tb_tiny_riscv_soc_top.sv
// Bench for tiny_riscv_soc_top: assembles a program (directed cases plus
// random ALU/store sequences), keeps an expected store stream and a memory
// image, and checks every data-bus store as the core issues it.
module tb_tiny_riscv_soc_top;
  import soc_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } st_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [31:0] prog[$];
  st_t         exp_all[$];
  st_t         exp_q[$];
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] reg_exp [int];

  always #5 clk = ~clk;

  tiny_riscv_soc_top #(.ROM_DEPTH(4096), .RAM_DEPTH(4096)) dut (
    .clk   (clk),
    .rst_n (rst_n)
  );

  soc_bus_if mon_bus ();
  assign mon_bus.addr  = dut.u_tinyriscv_core.dbus_addr;
  assign mon_bus.we    = dut.u_tinyriscv_core.dbus_we;
  assign mon_bus.be    = dut.u_tinyriscv_core.dbus_be;
  assign mon_bus.wdata = dut.u_tinyriscv_core.dbus_wdata;
  assign mon_bus.rdata = dut.u_tinyriscv_core.dbus_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h @%0t", name, act, exp, $time);
    end
  endtask

  // ---- assembler ----
  function automatic logic [31:0] enc_i(logic [6:0] op, logic [4:0] rd, logic [2:0] f3,
                                        logic [4:0] rs1, logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2,
                                        logic [11:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_u(logic [6:0] op, logic [4:0] rd, logic [19:0] imm);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] word_key(input logic [31:0] addr);
    return {addr[31:28], 14'b0, addr[13:2], 2'b00};
  endfunction

  task automatic emit(input logic [31:0] inst);
    mem_model[32'(prog.size()) * 4] = inst;
    prog.push_back(inst);
  endtask

  task automatic li(input logic [4:0] rd, input logic [31:0] v);
    logic [31:0] hi;
    hi = v + 32'h800;
    emit(enc_u(7'h37, rd, hi[31:12]));
    emit(enc_i(7'h13, rd, 3'b000, rd, v[11:0]));
  endtask

  // data: value already placed in its byte lanes
  task automatic exp_store(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
    st_t s;
    logic [31:0] k, w;
    s.addr = addr; s.be = be; s.data = data;
    exp_all.push_back(s);
    if (addr[31:28] <= 4'h1) begin
      k = word_key(addr);
      w = mem_model.exists(k) ? mem_model[k] : 32'h0;
      for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = data[8*i +: 8];
      mem_model[k] = w;
    end
  endtask

  task automatic build_program();
    logic [31:0] a, b, res, off;
    int op, mode, lane, sh;
    logic [2:0] f3;
    logic [6:0] f7;
    emit(enc_i(7'h13, 26, 3'b000, 0, 12'd1));          // addi x26,x0,1
    reg_exp[26] = 32'd1;
    emit(enc_u(7'h37, 10, 20'h10000));                 // x10 = RAM base
    for (int k = 0; k < 20; k++) begin
      a = $urandom; b = $urandom; op = $urandom_range(0, 9);
      if (k == 0) begin a = 32'h7FFF_FFFF; b = 32'd1; op = 0; end
      if (k == 1) begin a = 32'h8000_0000; b = 32'd31; op = 7; end
      if (k == 2) begin a = 32'h0; b = 32'hFFFF_FFFF; op = 3; end
      sh = int'(b % 32);
      f7 = 7'h00;
      case (op)
        0: begin f3 = 3'd0; res = a + b; end
        1: begin f3 = 3'd0; f7 = 7'h20; res = a - b; end
        2: begin f3 = 3'd1; res = a << sh; end
        3: begin f3 = 3'd2; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        4: begin f3 = 3'd3; res = (a < b) ? 32'd1 : 32'd0; end
        5: begin f3 = 3'd4; res = a ^ b; end
        6: begin f3 = 3'd5; res = a >> sh; end
        7: begin f3 = 3'd5; f7 = 7'h20; res = a[31] ? ~((~a) >> sh) : a >> sh; end
        8: begin f3 = 3'd6; res = a | b; end
        default: begin f3 = 3'd7; res = a & b; end
      endcase
      li(5'd1, a); li(5'd2, b);
      emit(enc_r(f7, 5'd2, 5'd1, f3, 5'd3));
      off = 32'h100 + 32'(4 * k);
      mode = (k < 3) ? 2 : $urandom_range(0, 2);
      if (mode == 0) begin
        lane = $urandom_range(0, 3);
        emit(enc_s(3'b000, 10, 3, 12'(off + 32'(lane))));
        exp_store(RAM_BASE + off + 32'(lane), 4'b0001 << lane, {24'b0, res[7:0]} << (8 * lane));
      end else if (mode == 1) begin
        lane = $urandom_range(0, 1);
        emit(enc_s(3'b001, 10, 3, 12'(off + 32'(2 * lane))));
        exp_store(RAM_BASE + off + 32'(2 * lane), 4'b0011 << (2 * lane),
                  {16'b0, res[15:0]} << (16 * lane));
      end else begin
        emit(enc_s(3'b010, 10, 3, 12'(off)));
        exp_store(RAM_BASE + off, 4'hF, res);
      end
    end
    // byte enables over 0x11223344
    li(5'd4, 32'h1122_3344);
    emit(enc_s(3'b010, 10, 4, 12'h040));
    exp_store(RAM_BASE + 32'h40, 4'hF, 32'h1122_3344);
    emit(enc_i(7'h13, 5, 3'b000, 0, 12'h0AB));
    emit(enc_s(3'b000, 10, 5, 12'h041));
    exp_store(RAM_BASE + 32'h41, 4'b0010, 32'h0000_AB00);
    emit(enc_i(7'h03, 20, 3'b100, 10, 12'h041));       // lbu x20
    reg_exp[20] = 32'h0000_00AB;
    // ROM write through the data port
    li(5'd6, 32'hDEAD_BEEF);
    emit(enc_u(7'h37, 7, 20'h00002));                  // x7 = 0x2000
    emit(enc_s(3'b010, 7, 6, 12'h000));
    exp_store(32'h0000_2000, 4'hF, 32'hDEAD_BEEF);
    emit(enc_i(7'h03, 21, 3'b010, 7, 12'h000));        // lw x21
    reg_exp[21] = 32'hDEAD_BEEF;
    // unmapped store/load
    emit(enc_u(7'h37, 8, 20'h20000));                  // x8 = 0x2000_0000
    emit(enc_i(7'h13, 22, 3'b000, 0, 12'd5));
    emit(enc_s(3'b010, 8, 6, 12'h000));
    exp_store(32'h2000_0000, 4'hF, 32'hDEAD_BEEF);
    emit(enc_i(7'h03, 22, 3'b010, 8, 12'h000));        // lw x22 -> 0
    reg_exp[22] = 32'h0;
    emit(enc_i(7'h13, 0, 3'b000, 0, 12'd5));           // x0 stays 0
    reg_exp[0] = 32'h0;
    // signature bounds and end flag
    li(5'd9, 32'h0000_2000);
    emit(enc_s(3'b010, 10, 9, 12'h008));
    exp_store(RAM_BASE + 32'h8, 4'hF, 32'h0000_2000);
    li(5'd9, 32'h0000_2004);
    emit(enc_s(3'b010, 10, 9, 12'h00C));
    exp_store(RAM_BASE + 32'hC, 4'hF, 32'h0000_2004);
    emit(enc_i(7'h13, 11, 3'b000, 0, 12'd1));
    emit(enc_s(3'b010, 10, 11, 12'h010));
    exp_store(RAM_BASE + 32'h10, 4'hF, 32'h1);
    emit(32'h0000_006F);                               // jal x0,0
  endtask

  // ---- store monitor ----
  always @(negedge clk) begin
    st_t e;
    logic [31:0] mask;
    if (mon_bus.we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("store_unexpected", mon_bus.addr, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        mask = '0;
        for (int i = 0; i < 4; i++) if (e.be[i]) mask[8*i +: 8] = 8'hFF;
        check("store_addr", mon_bus.addr, e.addr);
        check("store_be", {28'b0, mon_bus.be}, {28'b0, e.be});
        check("store_data", mon_bus.wdata & mask, e.data & mask);
      end
    end
  end

  task automatic check_mem(input string tag);
    foreach (mem_model[k]) begin
      logic [31:0] act;
      if (k[28]) act = dut.u_ram.u_gen_ram.ram[k[13:2]];
      else       act = dut.u_rom.u_gen_ram.ram[k[13:2]];
      check(tag, act, mem_model[k]);
    end
  endtask

  task automatic check_regs(input string tag);
    foreach (reg_exp[r]) check(tag, dut.u_tinyriscv_core.u_gpr_reg.regs[r], reg_exp[r]);
  endtask

  task automatic check_in_reset();
    int nz;
    nz = 0;
    for (int r = 0; r < 32; r++)
      if (dut.u_tinyriscv_core.u_gpr_reg.regs[r] !== 32'h0) nz++;
    check("reset_pc", dut.u_tinyriscv_core.ibus_addr, 32'h0);
    check("reset_gpr_nonzero", 32'(nz), 32'h0);
  endtask

  task automatic run_until_drained(input string tag);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 25000) begin
      @(posedge clk); c++;
    end
    repeat (3) @(posedge clk);
    #1;
    check(tag, 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    int c;
    logic done;
    build_program();
    #1 rst_n = 1'b0;
    for (int i = 0; i < prog.size(); i++) dut.u_rom.u_gen_ram.ram[i] <= prog[i];
    for (int i = 0; i < 128; i++) begin
      dut.u_ram.u_gen_ram.ram[i] <= (i == 0) ? 32'h5A5A_5A5A : 32'h0;
      mem_model[RAM_BASE + 32'(4 * i)] = (i == 0) ? 32'h5A5A_5A5A : 32'h0;
    end
    // replay program stores into the model (preload above overwrote them)
    foreach (exp_all[i]) begin
      st_t s; logic [31:0] k, w;
      s = exp_all[i];
      if (s.addr[31:28] <= 4'h1) begin
        k = word_key(s.addr);
        w = mem_model[k];
        for (int j = 0; j < 4; j++) if (s.be[j]) w[8*j +: 8] = s.data[8*j +: 8];
        mem_model[k] = w;
      end
    end
    repeat (3) @(negedge clk);
    check_in_reset();
    foreach (exp_all[i]) exp_q.push_back(exp_all[i]);

    rst_n = 1'b1;
    c = 0; done = 1'b0;
    while (!done && c < 10) begin
      @(posedge clk); #1; c++;
      if (dut.u_tinyriscv_core.u_gpr_reg.regs[26] === 32'd1) done = 1'b1;
    end
    check("x26_start", dut.u_tinyriscv_core.u_gpr_reg.regs[26], 32'd1);

    c = 0; done = 1'b0;
    while (!done && c < 25000) begin
      @(posedge clk); #1; c++;
      if (dut.u_ram.u_gen_ram.ram[4] === 32'd1) done = 1'b1;
    end
    check("end_flag", dut.u_ram.u_gen_ram.ram[4], 32'd1);
    run_until_drained("stores_drained");
    check("byte_en_word", dut.u_ram.u_gen_ram.ram[16], 32'h1122_AB44);
    check("rom_write", dut.u_rom.u_gen_ram.ram[12'h800], 32'hDEAD_BEEF);
    check_mem("mem_run1");
    check_regs("gpr_run1");

    @(negedge clk) rst_n = 1'b0;
    #1 check_in_reset();
    repeat (2) @(negedge clk);
    check_mem("mem_after_reset");
    foreach (exp_all[i]) exp_q.push_back(exp_all[i]);
    rst_n = 1'b1;
    run_until_drained("stores_drained_rerun");
    check_mem("mem_run2");
    check_regs("gpr_run2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tiny_riscv_soc_top.md
# tiny_riscv_soc_top

Top-level SoC integration for the tinyriscv RV32I core. It instantiates the existing core, a program memory (ROM) and a data memory (RAM), and decodes the core's data-bus addresses onto them. The block is the simulation and compliance-test top: the program image is preloaded into ROM, and results are read from memory and the core's register file by hierarchical path.

## Interface
- `ROM_DEPTH`, default 4096: ROM size in 32-bit words (16 KiB).
- `RAM_DEPTH`, default 4096: RAM size in 32-bit words (16 KiB).
- `clk`, input, 1 bit: system clock. All logic is on the rising edge (50 MHz nominal).
- `rst_n`, input, 1 bit: reset, asynchronous and active-low.
- No other ports in this configuration. JTAG/debug is out of scope.

## Operation
- Internal reset: a 2-flop synchronizer on `rst_n`.
  - Assertion is asynchronous.
  - Deassertion is synchronous, 2 cycles after `rst_n` rises.
  - Feeds the core.
- Core instance `u_tinyriscv_core` contains `u_gpr_reg.regs[0:31]`. Each entry is 32 bits and x0 reads 0.
- Core ports:
  - Instruction port: `ibus_addr[31:0]` out, `ibus_rdata[31:0]` in.
  - Data port: `dbus_addr[31:0]`, `dbus_we`, `dbus_be[3:0]`, `dbus_wdata[31:0]` out; `dbus_rdata[31:0]` in.
- Memory map, decoded on `addr[31:28]`:
  - 0x0: ROM, base 0x0000_0000.
  - 0x1: RAM, base 0x1000_0000.
  - Any other value is unmapped.
- Word index is `addr[log2(DEPTH)+1:2]`. Higher offset bits are ignored, so offsets wrap inside a region.
- Instruction fetch always reads ROM, regardless of `ibus_addr[31:28]`.
- ROM is dual-port:
  - Port A: instruction read.
  - Port B: data read/write.
  - ROM is writable from the data port, because compliance signatures are stored inside the ROM image.
- RAM is single-port on the data bus.
- Writes:
  - Synchronous, byte-masked by `dbus_be`. Byte i corresponds to `wdata[8i+7:8i]`.
  - Only the decoded slave is written.
- Reads:
  - Combinational from the array.
  - `dbus_rdata` is muxed by the decode of the current `dbus_addr`.
  - Unmapped reads return 0.
  - Unmapped writes are dropped.
- Memory contents are not affected by reset.
- Testbench memory contract (word indices in RAM):
  - `ram[2]`: signature begin (byte address).
  - `ram[3]`: signature end (byte address).
  - `ram[4]`: end flag; 1 means done.

## Timing
- Reads have zero-cycle latency: data is valid in the same cycle as the address.
- A write commits on the rising edge where `dbus_we`=1.
- Same-address read and write in the same cycle, on either ROM port: the read returns the old data and the new data is visible next cycle.
- In reset: core PC = 0x0000_0000 and GPRs = 0. The first fetch is from ROM word 0, on the first cycle after synchronized reset release.
- Reset asserted mid-operation: the core returns to reset state immediately. A store in flight that cycle is not guaranteed. Memory keeps its contents.

## Structure
- Shared package `soc_pkg`:
  - `ROM_BASE`, `RAM_BASE`, region-select field position.
  - Default depths.
  - Bus width, 32.
- One natural sub-module: `gen_ram`, a parameterised dual-port, byte-enable, combinational-read memory with array `ram[0:DEPTH-1]`.
- `gen_ram` wrappers:
  - `u_rom.u_gen_ram`: both ports used.
  - `u_ram.u_gen_ram`: port A tied off.
- These hierarchical names are mandatory; the bench preloads ROM with `$readmemh` and probes these paths.
- The core is an existing block and is not re-specified here.

## Test plan
- **Program start:** preload ROM with `addi x26,x0,1` at word 0 and release reset. → x26 = 1 within 10 cycles of release.
- **RAM end flag:** store 1 to 0x1000_0010. → `u_ram.u_gen_ram.ram[4]` = 0x1 next cycle, and the test completes well under 25 000 cycles.
- **Byte enables:** `sb` 0xAB to 0x1000_0001 over a word holding 0x11223344. → word = 0x1122AB44. `lbu` from the same address returns 0xAB.
- **ROM write via data port:** store 0xDEADBEEF to 0x0000_2000. → `u_rom.u_gen_ram.ram[0x800]` = 0xDEADBEEF, and a load returns the same value.
- **Unmapped access:** store to 0x2000_0000, then load it. → load returns 0, and ROM/RAM contents are unchanged.
- **Reset mid-run:** drop `rst_n` for 2 cycles mid-program. → PC restarts at 0, GPRs read 0, and RAM contents are preserved.
